// File: rtl/data_memory_responder.sv
// data_memory_responder: RV32I load/store responder backed by a word-organised RAM.
// Latency: request accepted at T, response valid at T+1+WAIT_CYCLES; one request in flight.
// Backpressure: req_ready only in IDLE; the response is held stable until resp_ready.
//
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   req_valid/req_ready     request handshake; req_write, req_addr, req_funct3, req_wdata
//   resp_valid/resp_ready   response handshake; resp_rdata, resp_error
//   busy                    high while a request is being served (WAIT or RESP)
// Optional feature: define MISALIGN_TRAP_EN to turn misaligned halfword/word
// accesses into errors; otherwise the low address bits are truncated.
module data_memory_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int ADDR_BITS = IDX_W + 2;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;

  logic        cap_write;
  logic [31:0] cap_addr;
  logic [2:0]  cap_funct3;
  logic [31:0] cap_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  logic        req_hs;
  logic        do_access;

  // Signals describing the access performed on the edge that enters RESP.
  logic             acc_write;
  logic [31:0]      acc_addr;
  logic [2:0]       acc_funct3;
  logic [31:0]      acc_wdata;
  logic [IDX_W-1:0] acc_idx;
  logic [1:0]       acc_lane;
  logic             acc_err;
  logic             f3_ok;
  logic             addr_err;
  logic             misalign;
  logic [3:0]       wr_lanes;
  logic [31:0]      wr_mask;
  logic [31:0]      wr_data;
  logic [31:0]      rd_word;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [31:0]      ld_val;
  logic             mem_we;

  assign req_hs = req_valid && req_ready;

  // With zero wait states the access coincides with acceptance, so the
  // captured copy is not yet available; use the live request in IDLE.
  assign do_access = (WAIT_CYCLES == 0) ? (state == IDLE && req_hs)
                                        : (state == WAIT && cnt == 4'd1);

  assign acc_write  = (state == IDLE) ? req_write  : cap_write;
  assign acc_addr   = (state == IDLE) ? req_addr   : cap_addr;
  assign acc_funct3 = (state == IDLE) ? req_funct3 : cap_funct3;
  assign acc_wdata  = (state == IDLE) ? req_wdata  : cap_wdata;
  assign acc_idx    = acc_addr[ADDR_BITS-1:2];
  assign acc_lane   = acc_addr[1:0];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_hs) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (cnt == 4'd1) state_nxt = RESP;
      RESP: if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    req_ready  = (state == IDLE) && !reset;
    resp_valid = (state == RESP);
    busy       = (state == WAIT) || (state == RESP);
  end

  // Wait counter and request capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      cap_write  <= 1'b0;
      cap_addr   <= '0;
      cap_funct3 <= '0;
      cap_wdata  <= '0;
    end else begin
      if (state == IDLE && req_hs) begin
        cnt        <= WAIT_CNT;
        cap_write  <= req_write;
        cap_addr   <= req_addr;
        cap_funct3 <= req_funct3;
        cap_wdata  <= req_wdata;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // ---------------- Access decode ----------------
  always_comb begin
    f3_ok    = acc_write ? (acc_funct3 == 3'b000 || acc_funct3 == 3'b001 || acc_funct3 == 3'b010)
                         : (acc_funct3 == 3'b000 || acc_funct3 == 3'b001 || acc_funct3 == 3'b010 ||
                            acc_funct3 == 3'b100 || acc_funct3 == 3'b101);
    addr_err = |acc_addr[31:ADDR_BITS];
`ifdef MISALIGN_TRAP_EN
    misalign = (acc_funct3[1:0] == 2'b01 && acc_addr[0]) ||
               (acc_funct3[1:0] == 2'b10 && acc_addr[1:0] != 2'b00);
`else
    misalign = 1'b0;
`endif
    acc_err  = !f3_ok || addr_err || misalign;
  end

  // Store lanes; data is replicated so every enabled lane sees its bytes.
  always_comb begin
    wr_lanes = 4'b1111;
    wr_data  = acc_wdata;
    case (acc_funct3[1:0])
      2'b00: begin
        wr_lanes = 4'b0001 << acc_lane;
        wr_data  = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        wr_lanes = acc_addr[1] ? 4'b1100 : 4'b0011;
        wr_data  = {2{acc_wdata[15:0]}};
      end
      default: begin
        wr_lanes = 4'b1111;
        wr_data  = acc_wdata;
      end
    endcase
    wr_mask = {{8{wr_lanes[3]}}, {8{wr_lanes[2]}}, {8{wr_lanes[1]}}, {8{wr_lanes[0]}}};
  end

  assign mem_we = do_access && acc_write && !acc_err && !reset;

  // Load extraction and extension.
  always_comb begin
    rd_word = mem[acc_idx];
    case (acc_lane)
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (acc_funct3)
      3'b000:  ld_val = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  ld_val = {24'd0, rd_byte};
      3'b001:  ld_val = {{16{rd_half[15]}}, rd_half};
      3'b101:  ld_val = {16'd0, rd_half};
      3'b010:  ld_val = rd_word;
      default: ld_val = 32'd0;
    endcase
  end

  // Response registers, loaded on the access edge and held through RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else if (do_access) begin
      resp_rdata <= (acc_err || acc_write) ? 32'd0 : ld_val;
      resp_error <= acc_err;
    end
  end

  // RAM: every word clears in the reset cycle; stores merge enabled lanes.
  for (genvar w = 0; w < DEPTH_WORDS; w++) begin : g_word
    always_ff @(posedge clk) begin
      if (reset)
        mem[w] <= '0;
      else if (mem_we && acc_idx == IDX_W'(w))
        mem[w] <= (mem[w] & ~wr_mask) | (wr_data & wr_mask);
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder (DEPTH_WORDS=64, WAIT_CYCLES=2).
module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        busy;

  int checks = 0;
  int errors = 0;

  data_memory_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request and collect its response; lat counts cycles from acceptance.
  task automatic xact(input logic w, input logic [31:0] a, input logic [2:0] f3,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er,
                      output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_funct3 = f3; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 20);
    if (!resp_valid) check("resp_timeout", {31'd0, resp_valid}, 32'd1);
    rd = resp_rdata;
    er = resp_error;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic ld(input string tag, input logic [31:0] a, input logic [2:0] f3,
                    input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] rd; logic er; int lat;
    xact(1'b0, a, f3, 32'd0, rd, er, lat);
    check({tag, "_data"}, rd, exp_d);
    check({tag, "_err"}, {31'd0, er}, {31'd0, exp_e});
  endtask

  task automatic st(input string tag, input logic [31:0] a, input logic [2:0] f3,
                    input logic [31:0] wd, input logic exp_e);
    logic [31:0] rd; logic er; int lat;
    xact(1'b1, a, f3, wd, rd, er, lat);
    check({tag, "_err"}, {31'd0, er}, {31'd0, exp_e});
    check({tag, "_rdata"}, rd, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;
    logic        seen;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_funct3 = '0; req_wdata = '0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready_low", {31'd0, req_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_error", {31'd0, resp_error}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // Word store then load, with latency.
    xact(1'b1, 32'h8, 3'b010, 32'hDEADBEEF, rd, er, lat);
    check("sw_latency", 32'(lat), 32'd3);
    check("sw_err", {31'd0, er}, 32'd0);
    ld("lw8", 32'h8, 3'b010, 32'hDEADBEEF, 1'b0);

    // Byte lanes.
    st("sb9", 32'h9, 3'b000, 32'h00000081, 1'b0);
    ld("lb9", 32'h9, 3'b000, 32'hFFFFFF81, 1'b0);
    ld("lbu9", 32'h9, 3'b100, 32'h00000081, 1'b0);
    ld("lw8_b", 32'h8, 3'b010, 32'hDEAD81EF, 1'b0);

    // Halfword lanes.
    st("sha", 32'hA, 3'b001, 32'h00001234, 1'b0);
    ld("lw8_h", 32'h8, 3'b010, 32'h123481EF, 1'b0);
    ld("lha", 32'hA, 3'b001, 32'h00001234, 1'b0);
    ld("lhu8", 32'h8, 3'b101, 32'h000081EF, 1'b0);

    // Misalignment.
    st("sw4", 32'h4, 3'b010, 32'h11112222, 1'b0);
`ifdef MISALIGN_TRAP_EN
    ld("lw6_trap", 32'h6, 3'b010, 32'h0, 1'b1);
    st("sw5_trap", 32'h5, 3'b010, 32'hAAAAAAAA, 1'b1);
    ld("lw4_kept", 32'h4, 3'b010, 32'h11112222, 1'b0);
`else
    ld("lw6_trunc", 32'h6, 3'b010, 32'h11112222, 1'b0);
    ld("lh7_trunc", 32'h7, 3'b001, 32'h00001111, 1'b0);
`endif

    // Backpressure: hold the response for 5 cycles with a competing request.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8; req_funct3 = 3'b010;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 20);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0; req_funct3 = 3'b010;
    req_wdata = 32'h55555555;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, resp_valid}, 32'd1);
      check("bp_rdata", resp_rdata, 32'h123481EF);
      check("bp_error", {31'd0, resp_error}, 32'd0);
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
      check("bp_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0; req_valid = 1'b0;
    check("bp_idle_ready", {31'd0, req_ready}, 32'd1);
    check("bp_idle_valid", {31'd0, resp_valid}, 32'd0);
    ld("bp_no_write", 32'h0, 3'b010, 32'h0, 1'b0);

    // Errors.
    ld("lw_oob", 32'h100, 3'b010, 32'h0, 1'b1);
    st("st_f3_100", 32'h0, 3'b100, 32'h12345678, 1'b1);
    ld("ld_f3_011", 32'h8, 3'b011, 32'h0, 1'b1);
    ld("after_errs", 32'h0, 3'b010, 32'h0, 1'b0);

    // Reset during WAIT aborts the store; a request during reset is ignored.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0; req_funct3 = 3'b010;
    req_wdata = 32'hFFFFFFFF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rw_busy_wait", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    req_valid = 1'b1; req_addr = 32'h4; req_wdata = 32'h77777777;
    #1;
    check("rw_ready_in_reset", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0;
    #1;
    check("rw_busy_after", {31'd0, busy}, 32'd0);
    check("rw_ready_after", {31'd0, req_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seen = seen | resp_valid;
    end
    check("rw_no_resp", {31'd0, seen}, 32'd0);
    ld("rw_lw0", 32'h0, 3'b010, 32'h0, 1'b0);
    ld("rw_lw4", 32'h4, 3'b010, 32'h0, 1'b0);
    ld("rw_lw8_cleared", 32'h8, 3'b010, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
